// File: rtl/single_cycle_uprocessor_pkg.sv
// Shared encodings for the calculator core: ALU/immediate/operand-B selects,
// condition codes, data-processing opcodes, calculator memory map and firmware encoders.
package single_cycle_uprocessor_pkg;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11} alu_ctrl_e;
  typedef enum logic [1:0] {IMM_8 = 2'b00, IMM_12 = 2'b01, IMM_24 = 2'b10, IMM_RSVD = 2'b11} imm_src_e;
  typedef enum logic [1:0] {SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01} alu_src_e;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE;

  localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;

  localparam logic [31:0] CALC_OP_ADDR  = 32'd0;
  localparam logic [31:0] CALC_A_ADDR   = 32'd16;
  localparam logic [31:0] CALC_B_ADDR   = 32'd20;
  localparam logic [31:0] CALC_RES_ADDR = 32'd24;

  // nzcv = {N, Z, C, V}; condition 4'hF never executes in this core
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // LDR/STR Rd,[R0,#off] with P=1 U=1 B=0 W=0
  function automatic logic [31:0] enc_mem(input logic load, input logic [3:0] rd, input logic [11:0] off);
    return {COND_AL, 2'b01, 5'b01100, load, 4'd0, rd, off};
  endfunction

  function automatic logic [31:0] enc_cmp_imm(input logic [3:0] rn, input logic [7:0] imm);
    return {COND_AL, 2'b00, 1'b1, CMD_CMP, 1'b1, rn, 4'd0, 4'd0, imm};
  endfunction

  function automatic logic [31:0] enc_dp_reg(input logic [3:0] cond, input logic [3:0] cmd,
                                             input logic [3:0] rd, input logic [3:0] rn,
                                             input logic [3:0] rm);
    return {cond, 2'b00, 1'b0, cmd, 1'b0, rn, rd, 8'd0, rm};
  endfunction

endpackage

// File: rtl/single_cycle_control.sv
// Instruction decoder plus condition check and NZCV flag register.
// Unsupported encodings decode as illegal and never write state.
module single_cycle_control
  import single_cycle_uprocessor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [3:0]  alu_flags,
  output logic        pc_src,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  alu_control,
  output logic [1:0]  alu_src,
  output logic [1:0]  imm_src,
  output logic [1:0]  reg_src
);
  logic       legal, branch, reg_w, mem_w, load, exec;
  logic [1:0] flag_w;
  logic [3:0] flags_q, flags_d;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^{instr[19:16], instr[3:0]};

  always_comb begin
    legal       = 1'b0;
    branch      = 1'b0;
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    load        = 1'b0;
    flag_w      = 2'b00;
    alu_control = ALU_ADD;
    alu_src     = SRCB_RD2;
    imm_src     = IMM_8;
    reg_src     = 2'b00;
    case (instr[27:26])
      2'b00: begin
        // immediate must be unrotated, register operand must be unshifted
        legal   = instr[25] ? (instr[11:8] == 4'd0) : (instr[11:4] == 8'd0);
        alu_src = instr[25] ? SRCB_IMM : SRCB_RD2;
        reg_w   = 1'b1;
        case (instr[24:21])
          CMD_ADD: alu_control = ALU_ADD;
          CMD_SUB: alu_control = ALU_SUB;
          CMD_AND: alu_control = ALU_AND;
          CMD_ORR: alu_control = ALU_ORR;
          CMD_CMP: begin
            alu_control = ALU_SUB;
            reg_w       = 1'b0;
            legal       = legal & instr[20];
          end
          default: legal = 1'b0;
        endcase
        // logical ops only own N and Z
        if (instr[20]) flag_w = alu_control[1] ? 2'b10 : 2'b11;
      end
      2'b01: begin
        legal   = (instr[25:21] == 5'b01100);
        load    = instr[20];
        reg_w   = instr[20];
        mem_w   = ~instr[20];
        alu_src = SRCB_IMM;
        imm_src = IMM_12;
        reg_src = {~instr[20], 1'b0};
      end
      2'b10: begin
        legal   = (instr[25:24] == 2'b10);
        branch  = 1'b1;
        alu_src = SRCB_IMM;
        imm_src = IMM_24;
        reg_src = 2'b01;
      end
      default: legal = 1'b0;
    endcase
  end

  assign exec       = legal & cond_holds(instr[31:28], flags_q);
  assign pc_src     = exec & (branch | (reg_w & (instr[15:12] == 4'd15)));
  assign reg_write  = exec & reg_w;
  assign mem_write  = exec & mem_w;
  assign mem_to_reg = exec & load;

  always_comb begin
    flags_d = flags_q;
    if (exec && flag_w[1]) flags_d[3:2] = alu_flags[3:2];
    if (exec && flag_w[0]) flags_d[1:0] = alu_flags[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

endmodule

// File: rtl/single_cycle_uprocessor.sv
// Single-cycle ARM-subset core running a fixed calculator loop from ROM.
// Data memory is shared with the calculator front end through an active-low write port.
module single_cycle_uprocessor
  import single_cycle_uprocessor_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] EntradaCalcu,
  input  logic [31:0] addressCalcu,
  input  logic        writeEnableCalcu,
  output logic [31:0] resultadoCalcu,
  output logic [31:0] RD2,
  output logic [31:0] RD1,
  output logic [3:0]  RA1,
  output logic        PCSrc,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ALUSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  ALUFlags,
  output logic [31:0] Instr,
  output logic [31:0] ALUResult,
  output logic [31:0] SrcB,
  output logic [31:0] Result
);
  logic [31:0] pc_q, pc_d, pc_plus4, pc_plus8;
  logic [31:0] rf_q [15];
  logic [31:0] mem_q [64] = '{default: '0};
  logic [3:0]  ra2, wa3;
  logic [31:0] ext_imm, b_op, read_data;
  logic [32:0] sum;
  logic        is_sub, arith, ext_we, proc_we;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{addressCalcu[31:8], addressCalcu[1:0]};

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;

  always_comb begin
    case (pc_q[5:2])
      4'd0:    Instr = enc_mem(1'b1, 4'd1, CALC_OP_ADDR[11:0]);
      4'd1:    Instr = enc_mem(1'b1, 4'd2, CALC_A_ADDR[11:0]);
      4'd2:    Instr = enc_mem(1'b1, 4'd3, CALC_B_ADDR[11:0]);
      4'd3:    Instr = enc_cmp_imm(4'd1, 8'd0);
      4'd4:    Instr = enc_dp_reg(COND_EQ, CMD_ADD, 4'd4, 4'd2, 4'd3);
      4'd5:    Instr = enc_cmp_imm(4'd1, 8'd1);
      4'd6:    Instr = enc_dp_reg(COND_EQ, CMD_SUB, 4'd4, 4'd2, 4'd3);
      4'd7:    Instr = enc_cmp_imm(4'd1, 8'd2);
      4'd8:    Instr = enc_dp_reg(COND_EQ, CMD_AND, 4'd4, 4'd2, 4'd3);
      4'd9:    Instr = enc_cmp_imm(4'd1, 8'd3);
      4'd10:   Instr = enc_dp_reg(COND_EQ, CMD_ORR, 4'd4, 4'd2, 4'd3);
      4'd11:   Instr = enc_mem(1'b0, 4'd4, CALC_RES_ADDR[11:0]);
      4'd12:   Instr = {COND_AL, 3'b101, 1'b0, 24'hFFFFF2};
      default: Instr = {4'hF, 28'd0};
    endcase
  end

  single_cycle_control u_ctrl (
    .clk        (CLK),
    .rst        (RESET),
    .instr      (Instr),
    .alu_flags  (ALUFlags),
    .pc_src     (PCSrc),
    .mem_to_reg (MemtoReg),
    .mem_write  (MemWrite),
    .reg_write  (RegWrite),
    .alu_control(ALUControl),
    .alu_src    (ALUSrc),
    .imm_src    (ImmSrc),
    .reg_src    (RegSrc)
  );

  // R15 is not stored; it reads as PC+8
  assign RA1 = RegSrc[0] ? 4'd15 : Instr[19:16];
  assign ra2 = RegSrc[1] ? Instr[15:12] : Instr[3:0];
  assign wa3 = Instr[15:12];
  assign RD1 = (RA1 == 4'd15) ? pc_plus8 : rf_q[RA1];
  assign RD2 = (ra2 == 4'd15) ? pc_plus8 : rf_q[ra2];

  always_comb begin
    case (ImmSrc)
      IMM_8:   ext_imm = {24'd0, Instr[7:0]};
      IMM_12:  ext_imm = {20'd0, Instr[11:0]};
      IMM_24:  ext_imm = {{6{Instr[23]}}, Instr[23:0], 2'b00};
      default: ext_imm = '0;
    endcase
  end

  assign SrcB   = (ALUSrc == SRCB_IMM) ? ext_imm : RD2;
  assign is_sub = (ALUControl == ALU_SUB);
  assign arith  = ~ALUControl[1];
  assign b_op   = is_sub ? ~SrcB : SrcB;
  assign sum    = {1'b0, RD1} + {1'b0, b_op} + {32'd0, is_sub};

  always_comb begin
    case (ALUControl)
      ALU_AND: ALUResult = RD1 & SrcB;
      ALU_ORR: ALUResult = RD1 | SrcB;
      default: ALUResult = sum[31:0];
    endcase
    ALUFlags = {ALUResult[31], ALUResult == 32'd0, arith & sum[32],
                arith & (RD1[31] == b_op[31]) & (sum[31] != RD1[31])};
  end

  assign read_data      = mem_q[ALUResult[7:2]];
  assign Result         = MemtoReg ? read_data : ALUResult;
  assign resultadoCalcu = mem_q[CALC_RES_ADDR[7:2]];

  // external write is issued last so it wins a same-word collision with STR
  assign ext_we  = ~writeEnableCalcu;
  assign proc_we = MemWrite & ~RESET;

  always_ff @(posedge CLK) begin
    if (proc_we) mem_q[ALUResult[7:2]] <= RD2;
    if (ext_we)  mem_q[addressCalcu[7:2]] <= EntradaCalcu;
  end

  assign pc_d = PCSrc ? Result : pc_plus4;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= '0;
    end else if (RegWrite && wa3 != 4'd15) begin
      rf_q[wa3] <= Result;
    end
  end

endmodule

// File: tb/tb_single_cycle_uprocessor.sv
// Bench for the calculator core: firmware trace after reset, directed calculator
// cases, write-port corner cases, then randomized calculator jobs against a model.
module tb_single_cycle_uprocessor;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] EntradaCalcu = '0;
  logic [31:0] addressCalcu = '0;
  logic        writeEnableCalcu = 1'b1;
  logic [31:0] resultadoCalcu, RD2, RD1, Instr, ALUResult, SrcB, Result;
  logic [3:0]  RA1, ALUFlags;
  logic        PCSrc, MemtoReg, MemWrite, RegWrite;
  logic [1:0]  ALUControl, ALUSrc, ImmSrc, RegSrc;

  always #5 CLK = ~CLK;

  single_cycle_uprocessor u_dut (
    .CLK(CLK), .RESET(RESET), .EntradaCalcu(EntradaCalcu), .addressCalcu(addressCalcu),
    .writeEnableCalcu(writeEnableCalcu), .resultadoCalcu(resultadoCalcu),
    .RD2(RD2), .RD1(RD1), .RA1(RA1), .PCSrc(PCSrc), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUControl(ALUControl), .ALUSrc(ALUSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUFlags(ALUFlags), .Instr(Instr),
    .ALUResult(ALUResult), .SrcB(SrcB), .Result(Result)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] fw [13];
  logic [31:0] mdl_mem [64];
  logic [31:0] mdl_r4;

  localparam logic [31:0] STR_WORD = 32'hE5804018;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  // What the calculator firmware computes from opcode/A/B
  function automatic logic [31:0] calc(input logic [31:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] prev);
    case (op)
      32'd0:   return a + b;
      32'd1:   return a - b;
      32'd2:   return a & b;
      32'd3:   return a | b;
      default: return prev;
    endcase
  endfunction

  task automatic ext_write(input logic [31:0] addr, input logic [31:0] data, input logic we_n);
    @(negedge CLK);
    addressCalcu = addr; EntradaCalcu = data; writeEnableCalcu = we_n;
    @(negedge CLK);
    writeEnableCalcu = 1'b1;
    if (!we_n) mdl_mem[addr[7:2]] = data;
  endtask

  // opcode goes first so a loop that saw the old opcode also saw old operands
  task automatic job(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
    ext_write(32'd0, op, 1'b0);
    ext_write(32'd16, a, 1'b0);
    ext_write(32'd20, b, 1'b0);
  endtask

  task automatic settle_chk(input string tag);
    repeat (26) @(negedge CLK);
    mdl_r4 = calc(mdl_mem[0], mdl_mem[4], mdl_mem[5], mdl_r4);
    chk(tag, resultadoCalcu, mdl_r4);
  endtask

  task automatic sync_str();
    for (int i = 0; i < 16 && Instr !== STR_WORD; i++) @(negedge CLK);
    chk("sync_str", Instr, STR_WORD);
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fw = '{32'hE5901000, 32'hE5902010, 32'hE5903014, 32'hE3510000, 32'h00824003,
           32'hE3510001, 32'h00424003, 32'hE3510002, 32'h00024003, 32'hE3510003,
           32'h01824003, 32'hE5804018, 32'hEAFFFFF2};
    for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
    mdl_r4 = '0;

    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_instr", Instr, fw[0]);
    chk("rst_result", resultadoCalcu, 32'd0);
    chk("rst_alures", ALUResult, 32'd0);
    chk("rst_pcsrc", {31'd0, PCSrc}, 32'd0);

    // two full loops with all-zero memory: opcode 0 path taken
    for (int i = 0; i < 26; i++) begin
      chk($sformatf("fw_%0d", i), Instr, fw[i % 13]);
      if (i == 3)  chk("cmp0_flags", {28'd0, ALUFlags}, 32'h6);
      if (i == 4)  chk("addeq_we", {31'd0, RegWrite}, 32'd1);
      if (i == 5)  chk("cmp1_flags", {28'd0, ALUFlags}, 32'h8);
      if (i == 6)  chk("subeq_skip", {29'd0, RegWrite, ALUControl}, 32'h1);
      if (i == 11) chk("str_ctl", {29'd0, MemWrite, RegSrc}, 32'h6);
      if (i == 12) begin
        chk("b_pcsrc", {29'd0, PCSrc, ImmSrc}, 32'h6);
        chk("b_r15", RD1, 32'd56);
        chk("b_target", ALUResult, 32'd0);
      end
      @(negedge CLK);
    end
    chk("idle_result", resultadoCalcu, 32'd0);

    job(32'd1, 32'd99, 32'd10);
    settle_chk("sub_99_10");
    ext_write(32'd16, 32'd7, 1'b1);
    settle_chk("we_high_noop");
    ext_write(32'd0, 32'd7, 1'b0);
    settle_chk("op7_keep");
    job(32'd0, 32'hFFFF_FFFF, 32'd1);
    settle_chk("add_wrap");
    job(32'd2, 32'hF0, 32'h3C);
    settle_chk("and_f0_3c");
    job(32'd3, 32'hF0, 32'h3C);
    settle_chk("orr_f0_3c");

    // external write landing on the firmware STR edge
    sync_str();
    addressCalcu = 32'd24; EntradaCalcu = 32'hDEAD_BEEF; writeEnableCalcu = 1'b0;
    @(negedge CLK);
    writeEnableCalcu = 1'b1;
    chk("collide_ext", resultadoCalcu, 32'hDEAD_BEEF);
    repeat (13) @(negedge CLK);
    chk("collide_restore", resultadoCalcu, mdl_r4);

    // reset hitting the STR cycle drops the store and clears R4
    ext_write(32'd0, 32'd7, 1'b0);
    settle_chk("op7_pre_rst");
    ext_write(32'd24, 32'h5A5A_5A5A, 1'b0);
    sync_str();
    #4 RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_no_store", resultadoCalcu, 32'h5A5A_5A5A);
    RESET = 1'b0;
    mdl_r4 = '0;
    settle_chk("op7_post_rst");

    for (int n = 0; n < 20; n++) begin
      int          r;
      logic [31:0] op, a, b;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? r : (r < 6) ? 32'd4 + $urandom_range(0, 100) : (r == 6) ? $urandom : r % 4;
      a  = pick($urandom_range(0, 7));
      b  = pick($urandom_range(0, 7));
      job(op, a, b);
      ext_write({24'd0, 6'($urandom_range(7, 63)), 2'b00}, $urandom, 1'b0);
      ext_write({24'd0, 6'($urandom_range(0, 6)), 2'b00}, $urandom, 1'b1);
      settle_chk($sformatf("rand_%0d_op%0h", n, op));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
